// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-RAM port arbiter.
package mem_arb_pkg;

  localparam int unsigned ARB_ADDR_W       = 32;
  localparam int unsigned ARB_DATA_W       = 32;
  localparam int unsigned ARB_STARVE_LIMIT = 4;
  localparam int unsigned ARB_STARVE_CNT_W = $clog2(ARB_STARVE_LIMIT + 1);

  typedef enum logic {
    ARB_IDLE,
    ARB_ACCESS
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  // Request latched at grant and presented to the RAM during ACCESS.
  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic                  we;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, load/store port and RAM-side signals.
// slave  : arbiter side (drives grants, responses and RAM controls)
// master : core + RAM side (drives requests and RAM read data)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_clk_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_clk_en, mem_wr_en, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_clk_en, mem_wr_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Fetch starvation guard: counts cycles where a fetch is waiting while
// the load/store port wins, and raises force_i once the limit is hit.
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  input  logic d_gnt,
  output logic force_i
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of denied fetch opportunities, cleared by a fetch grant.
  always_comb begin
    cnt_d = cnt_q;
    if (i_gnt) begin
      cnt_d = '0;
    end else if (i_req && d_gnt && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign force_i = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified RAM between fetch (I) and
// load/store (D). Grant is combinational, the winner is latched and
// driven to the RAM for one ACCESS cycle, response is registered.
// Optional build macro: MEM_ARB_STARVE_GUARD_EN (fetch starvation guard).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ARB_ADDR_W,
  parameter int unsigned DATA_W       = ARB_DATA_W,
  parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  mem_req_t          req_q, req_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_rvalid_q, i_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              i_gnt, d_gnt;
  logic              force_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk     (clk),
    .rst     (rst),
    .i_req   (bus.i_req),
    .i_gnt   (i_gnt),
    .d_gnt   (d_gnt),
    .force_i (force_i)
  );
`else
  assign force_i = 1'b0;
`endif

  // Grant: D wins ties unless the starvation guard is forcing I; none in reset.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      d_gnt = bus.d_req && !(force_i && bus.i_req);
      i_gnt = bus.i_req && !d_gnt;
    end
  end

  // Next state: capture the RAM result for the current owner and latch a new winner.
  always_comb begin
    state_d    = ARB_IDLE;
    owner_d    = owner_q;
    req_d      = req_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;

    if (state_q == ARB_ACCESS) begin
      if (owner_q == OWN_I) begin
        i_rvalid_d = 1'b1;
        i_rdata_d  = bus.mem_rdata;
      end else begin
        d_rvalid_d = 1'b1;
        // Store acks leave the last load data in place.
        if (!req_q.we) d_rdata_d = bus.mem_rdata;
      end
    end

    if (d_gnt) begin
      state_d     = ARB_ACCESS;
      owner_d     = OWN_D;
      req_d.addr  = bus.d_addr;
      req_d.we    = bus.d_we;
      req_d.wdata = bus.d_wdata;
    end else if (i_gnt) begin
      state_d     = ARB_ACCESS;
      owner_d     = OWN_I;
      req_d.addr  = bus.i_addr;
      req_d.we    = 1'b0;
    end
  end

  // Arbiter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_I;
      req_q      <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      req_q      <= req_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
    end
  end

  // RAM enables are decoded from the state flop so reset kills a write at once.
  always_comb begin
    bus.i_gnt      = i_gnt;
    bus.d_gnt      = d_gnt;
    bus.i_rvalid   = i_rvalid_q;
    bus.i_rdata    = i_rdata_q;
    bus.d_rvalid   = d_rvalid_q;
    bus.d_rdata    = d_rdata_q;
    bus.mem_clk_en = (state_q == ARB_ACCESS);
    bus.mem_wr_en  = (state_q == ARB_ACCESS) && req_q.we;
    bus.mem_addr   = ADDR_W'(req_q.addr);
    bus.mem_wdata  = DATA_W'(req_q.wdata);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed
// by random traffic, checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, write on clock when enabled.
  logic [31:0] dmem [1024];
  assign bus.mem_rdata = dmem[bus.mem_addr[11:2]];
  always @(posedge clk) begin
    if (bus.mem_clk_en && bus.mem_wr_en) dmem[bus.mem_addr[11:2]] <= bus.mem_wdata;
  end

  // Reference model: accesses and responses scheduled at grant time.
  typedef struct { int due; bit we; logic [31:0] addr; logic [31:0] wdata; } acc_t;
  typedef struct { int due; bit is_d; bit store; logic [31:0] data; } rsp_t;
  acc_t        acc_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] ref_mem [1024];
  logic [31:0] last_i, last_d;
  int          starve_cnt;
  bit          gi_last, gd_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // One clock cycle: check outputs at negedge, update model, step to posedge+1.
  task automatic tick();
    bit   eg_i, eg_d, force_i, exp_iv, exp_dv;
    acc_t a;
    rsp_t r;
    int   idx;
    @(negedge clk);
`ifdef MEM_ARB_STARVE_GUARD_EN
    force_i = (starve_cnt == LIMIT);
`else
    force_i = 1'b0;
`endif
    eg_d = bus.d_req && !(force_i && bus.i_req);
    eg_i = bus.i_req && !eg_d;
    chk("i_gnt", bus.i_gnt, eg_i);
    chk("d_gnt", bus.d_gnt, eg_d);

    if (acc_q.size() > 0 && acc_q[0].due == cyc) begin
      a = acc_q.pop_front();
      chk("mem_clk_en", bus.mem_clk_en, 1);
      chk("mem_wr_en", bus.mem_wr_en, a.we);
      chk("mem_addr", bus.mem_addr, a.addr);
      if (a.we) chk("mem_wdata", bus.mem_wdata, a.wdata);
    end else begin
      chk("mem_clk_en_idle", bus.mem_clk_en, 0);
      chk("mem_wr_en_idle", bus.mem_wr_en, 0);
    end

    exp_iv = 1'b0;
    exp_dv = 1'b0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      r = rsp_q.pop_front();
      if (r.is_d) begin
        exp_dv = 1'b1;
        if (!r.store) last_d = r.data;
      end else begin
        exp_iv = 1'b1;
        last_i = r.data;
      end
    end
    chk("i_rvalid", bus.i_rvalid, exp_iv);
    chk("d_rvalid", bus.d_rvalid, exp_dv);
    if (exp_iv) chk("i_rdata", bus.i_rdata, last_i);
    if (exp_dv) chk("d_rdata", bus.d_rdata, last_d);

    if (eg_d) begin
      idx = int'(bus.d_addr[11:2]);
      acc_q.push_back('{cyc + 1, bus.d_we, bus.d_addr, bus.d_wdata});
      rsp_q.push_back('{cyc + 2, 1'b1, bus.d_we, ref_mem[idx]});
      if (bus.d_we) ref_mem[idx] = bus.d_wdata;
    end else if (eg_i) begin
      idx = int'(bus.i_addr[11:2]);
      acc_q.push_back('{cyc + 1, 1'b0, bus.i_addr, 32'h0});
      rsp_q.push_back('{cyc + 2, 1'b0, 1'b0, ref_mem[idx]});
    end
    if (eg_i) starve_cnt = 0;
    else if (bus.i_req && eg_d && starve_cnt < LIMIT) starve_cnt++;
    gi_last = eg_i;
    gd_last = eg_d;

    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_i_gnt"}, bus.i_gnt, 0);
    chk({tag, "_d_gnt"}, bus.d_gnt, 0);
    chk({tag, "_i_rvalid"}, bus.i_rvalid, 0);
    chk({tag, "_d_rvalid"}, bus.d_rvalid, 0);
    chk({tag, "_i_rdata"}, bus.i_rdata, 0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 0);
    chk({tag, "_mem_clk_en"}, bus.mem_clk_en, 0);
    chk({tag, "_mem_wr_en"}, bus.mem_wr_en, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  task automatic rand_addr(output logic [31:0] a);
    a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] old40, a;
    int          i_gnt_cnt;

    for (int k = 0; k < 1024; k++) begin
      dmem[k]    = $urandom;
      ref_mem[k] = dmem[k];
    end
    last_i = '0; last_d = '0; starve_cnt = 0; gi_last = 0; gd_last = 0;
    rst = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1;

    // Reset state: grants held low even with requests pending.
    #3;
    check_all_zero("reset");
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single fetch from 0x200.
    bus.i_req = 1'b1; bus.i_addr = 32'h200;
    tick();
    bus.i_req = 1'b0;
    repeat (3) tick();
    chk("fetch_0x200_data", bus.i_rdata, dmem[128]);

    // Store 0xDEADBEEF to 0x10, then load it back.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'hDEADBEEF;
    tick();
    bus.d_we = 1'b0; bus.d_wdata = 32'h0;
    tick();
    bus.d_req = 1'b0;
    repeat (3) tick();
    chk("load_back", bus.d_rdata, 32'hDEADBEEF);

    // Contention: D first, I next cycle.
    bus.i_req = 1'b1; bus.i_addr = 32'h84;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    tick();
    bus.d_req = 1'b0;
    tick();
    bus.i_req = 1'b0;
    repeat (3) tick();

    // Idle for 10 cycles.
    repeat (10) tick();

    // Starvation: both ports requesting continuously.
    i_gnt_cnt = 0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    for (int n = 0; n < 12; n++) begin
      rand_addr(a); bus.d_addr = a; bus.d_we = 1'($urandom_range(0, 1)); bus.d_wdata = $urandom;
      if (n == 4) i_gnt_cnt = int'(gi_last) + i_gnt_cnt;
      tick();
      if (n < 5 && gi_last) i_gnt_cnt++;
      if (gi_last) begin rand_addr(a); bus.i_addr = a; end
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("starve_i_gnt_first5", i_gnt_cnt, 1);
`else
    chk("starve_i_gnt_first5", i_gnt_cnt, 0);
`endif
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    repeat (3) tick();

    // Reset in the middle of a store access to 0x40.
    old40 = dmem[16];
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = ~old40;
    tick();
    bus.d_req = 1'b0;
    chk("midacc_wr_en_before", bus.mem_wr_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("midacc_wr_en_dropped", bus.mem_wr_en, 0);
    chk("midacc_clk_en_dropped", bus.mem_clk_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc++;
    acc_q.delete(); rsp_q.delete();
    ref_mem[16] = old40;
    last_i = '0; last_d = '0; starve_cnt = 0;
    chk("midacc_mem_unchanged", dmem[16], old40);
    check_all_zero("post_reset");
    repeat (3) tick();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if (!bus.i_req || gi_last) begin
        bus.i_req = 1'($urandom_range(0, 1));
        rand_addr(a); bus.i_addr = a;
      end
      if (!bus.d_req || gd_last) begin
        bus.d_req = 1'($urandom_range(0, 1));
        bus.d_we  = 1'($urandom_range(0, 1));
        rand_addr(a); bus.d_addr = {26'h0, a[5:2], 2'b00};
        bus.d_wdata = $urandom;
      end
      tick();
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
